// File: rtl/ext_mem_test_pkg.sv
// Shared constants, descriptor type and beat pattern generator for the external-memory test.
// Pure declarations; no timing or flow control of its own.
// Write and read paths both call exp_beat, so their patterns agree by construction.
package ext_mem_test_pkg;

    localparam int DATA_W     = 512;
    localparam int LANE_W     = 32;
    localparam int N_LANES    = 16;
    localparam int BEAT_BYTES = 64;
    localparam int DESC_W     = 40;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } chk_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_desc_t;

    function automatic logic [DATA_W-1:0] exp_beat(input logic [31:0] addr, input logic [31:0] seed);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_LANES; i++) begin
            v[i*LANE_W +: LANE_W] = (addr + 32'(i * 4)) ^ seed;
        end
        return v;
    endfunction

endpackage

// File: rtl/chk_addr_fifo.sv
// Synchronous descriptor FIFO with full/empty flags and a combinational read port.
// Latency: a push is visible at the head one cycle later; pop_dat_o is valid whenever not empty.
// Backpressure: pushes while full and pops while empty are ignored; clear_i empties it.
module chk_addr_fifo
    import ext_mem_test_pkg::*;
#(
    parameter int WIDTH = DESC_W,
    parameter int DEPTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB separates full from empty when the indices coincide.
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push && !clear_i) mem_q[wptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/rd_data_checker.sv
// Passive AXI read monitor: checks snooped R beats against the address pattern (CHK_ERR_SNAPSHOT_EN adds data capture).
// Latency: flags, counters and first_err_* update one cycle after the R handshake.
// Backpressure: none exerted; ARs arriving with the descriptor FIFO full are dropped and flagged.
module rd_data_checker
    import ext_mem_test_pkg::*;
#(
    parameter int          AFIFO_DEPTH = 8,
    parameter logic [31:0] PAT_SEED    = 32'h0000_0000,
    parameter int          CNT_W       = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clear,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    input  logic              RREADY,
    output logic              error_detect,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic [31:0]       first_err_addr,
    output logic [15:0]       first_err_lanes,
    output logic              afifo_ovf
`ifdef CHK_ERR_SNAPSHOT_EN
    ,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    chk_state_e        state_q, state_d;
    ar_desc_t          cur_q, cur_d;
    logic [7:0]        beat_idx_q, beat_idx_d;
    logic              ar_fire, r_fire, pop_req;
    logic              fifo_full, fifo_empty;
    logic [DESC_W-1:0] fifo_dat;
    logic              last_idx, burst_end, chk_beat, orphan, beat_err, any_err;
    logic [31:0]       beat_addr;
    logic [DATA_W-1:0] exp_vec;
    logic [15:0]       lane_mis;

    logic              err_det_q, ovf_q;
    logic [CNT_W-1:0]  err_cnt_q, beat_cnt_q, burst_cnt_q;
    logic [31:0]       ferr_addr_q;
    logic [15:0]       ferr_lanes_q;

    assign ar_fire = ARVALID && ARREADY;
    assign r_fire  = RVALID && RREADY;

    chk_addr_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (AFIFO_DEPTH)
    ) u_afifo (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .clear_i    (clear),
        .push_i     (ar_fire),
        .push_dat_i ({ARADDR, ARLEN}),
        .pop_i      (pop_req),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign last_idx  = (beat_idx_q == cur_q.len);
    assign chk_beat  = r_fire && (state_q == ST_ACTIVE);
    assign orphan    = r_fire && (state_q == ST_IDLE);
    assign burst_end = chk_beat && (RLAST || last_idx);
    assign beat_addr = cur_q.addr + (32'(beat_idx_q) << 6);
    assign exp_vec   = exp_beat(beat_addr, PAT_SEED);

    always_comb begin
        lane_mis = '0;
        for (int i = 0; i < N_LANES; i++) begin
            lane_mis[i] = (RDATA[i*LANE_W +: LANE_W] != exp_vec[i*LANE_W +: LANE_W]);
        end
    end

    assign beat_err = chk_beat && ((|lane_mis) || (RRESP != 2'b00) || (RLAST != last_idx));
    assign any_err  = beat_err || orphan;

    // A finishing burst hands straight over to the next descriptor so back-to-back bursts have no bubble.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        beat_idx_d = beat_idx_q;
        pop_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_req    = 1'b1;
                    cur_d      = ar_desc_t'(fifo_dat);
                    beat_idx_d = '0;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (burst_end) begin
                    if (!fifo_empty) begin
                        pop_req    = 1'b1;
                        cur_d      = ar_desc_t'(fifo_dat);
                        beat_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (chk_beat) begin
                    beat_idx_d = beat_idx_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            beat_idx_q   <= '0;
            err_det_q    <= 1'b0;
            ovf_q        <= 1'b0;
            err_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            ferr_addr_q  <= '0;
            ferr_lanes_q <= '0;
        end else if (clear) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            beat_idx_q   <= '0;
            err_det_q    <= 1'b0;
            ovf_q        <= 1'b0;
            err_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            ferr_addr_q  <= '0;
            ferr_lanes_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            beat_idx_q <= beat_idx_d;
            if (ar_fire && fifo_full) ovf_q <= 1'b1;
            if (chk_beat)  beat_cnt_q  <= sat_inc(beat_cnt_q);
            if (burst_end) burst_cnt_q <= sat_inc(burst_cnt_q);
            if (any_err) begin
                err_cnt_q <= sat_inc(err_cnt_q);
                err_det_q <= 1'b1;
                if (!err_det_q) begin
                    ferr_addr_q  <= orphan ? 32'hFFFF_FFFF : beat_addr;
                    ferr_lanes_q <= orphan ? 16'hFFFF : lane_mis;
                end
            end
        end
    end

`ifdef CHK_ERR_SNAPSHOT_EN
    logic [DATA_W-1:0] ferr_data_q, ferr_exp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ferr_data_q <= '0;
            ferr_exp_q  <= '0;
        end else if (clear) begin
            ferr_data_q <= '0;
            ferr_exp_q  <= '0;
        end else if (any_err && !err_det_q) begin
            ferr_data_q <= RDATA;
            ferr_exp_q  <= orphan ? '0 : exp_vec;
        end
    end

    assign first_err_data = ferr_data_q;
    assign first_err_exp  = ferr_exp_q;
`endif

    assign error_detect    = err_det_q;
    assign afifo_ovf       = ovf_q;
    assign err_cnt         = err_cnt_q;
    assign beat_cnt        = beat_cnt_q;
    assign burst_cnt       = burst_cnt_q;
    assign first_err_addr  = ferr_addr_q;
    assign first_err_lanes = ferr_lanes_q;

endmodule
